// File: rtl/sha3_scanner_array.sv
//==============================================================================
// Module      : sha3_scanner_array
// Description : Job dispatcher for CHANNELS sha3 scanner cores. Latches one
//               work blob, splits the nonce range across cores, and collects
//               found results through a round-robin arbiter into a
//               first-word fall-through result FIFO.
//               Optional feature macro: SHA3_SCANNER_EARLY_ABORT_EN
//               (adds ch_abort; the first result of a job stops the others).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sha3_scanner_array #(
  parameter int CHANNELS       = 2,
  parameter int INPUT_ELEMENTS = 20,
  parameter int NONCE_INDEX    = 19,
  parameter int RESULT_DEPTH   = 4,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [INPUT_ELEMENTS-1:0][31:0]                blobby,
  input  logic [63:0]                                    threshold,
  output logic                                           idle,
  output logic [31:0]                                    scan_count,
  output logic [CHANNELS-1:0]                            ch_start,
  output logic [CHANNELS-1:0][INPUT_ELEMENTS-1:0][31:0]  ch_blobby,
  output logic [63:0]                                    ch_threshold,
`ifdef SHA3_SCANNER_EARLY_ABORT_EN
  output logic [CHANNELS-1:0]                            ch_abort,
`endif
  input  logic [CHANNELS-1:0]                            ch_dispatching,
  input  logic [CHANNELS-1:0]                            ch_awaiting,
  input  logic [CHANNELS-1:0]                            ch_found,
  input  logic [CHANNELS-1:0][24:0][63:0]                ch_hash,
  input  logic [CHANNELS-1:0][31:0]                      ch_nonce,
  input  logic [CHANNELS-1:0][31:0]                      ch_scan_count,
  output logic                                           res_valid,
  input  logic                                           res_ready,
  output logic [24:0][63:0]                              res_hash,
  output logic [31:0]                                    res_nonce,
  output logic [CW-1:0]                                  res_channel,
  output logic                                           overflow,
  output logic [15:0]                                    found_count
);

  localparam int AW = $clog2(RESULT_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   run_seen;      // high from the second RUN cycle onward
  logic   accept;
  logic   cores_quiet;

  logic [INPUT_ELEMENTS-1:0][31:0] blob;

  logic [CHANNELS-1:0]              hold_valid;
  logic [CHANNELS-1:0][24:0][63:0]  hold_hash;
  logic [CHANNELS-1:0][31:0]        hold_nonce;
  logic [CHANNELS-1:0]              capture_gate;
  logic [CHANNELS-1:0]              take;
  logic [CHANNELS-1:0]              drop;
  logic [4:0]                       ncap;
  logic [16:0]                      found_sum;

  logic [CW-1:0]       last_grant;
  logic [CW-1:0]       grant_idx;
  logic                grant_any;
  logic [CHANNELS-1:0] grant_vec;
  int                  arb_idx;

  logic [24:0][63:0] mem_hash  [RESULT_DEPTH];
  logic [31:0]       mem_nonce [RESULT_DEPTH];
  logic [CW-1:0]     mem_chan  [RESULT_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              fifo_full;
  logic              push, pop, can_push;

  logic unused_scan_bits;

  assign accept      = start & (state == S_IDLE);
  assign cores_quiet = ~|(ch_awaiting | ch_dispatching);
  assign scan_count  = ch_scan_count[0] * 32'(CHANNELS);
  // Only core 0's scan count sets the nonce stride; the rest are informational.
  assign unused_scan_bits = ^ch_scan_count;

  // FSM state register plus the "second RUN cycle" marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      run_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_seen <= (state == S_RUN);
    end
  end

  // FSM next-state and status outputs
  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    ch_start  = '0;
    case (state)
      S_IDLE: begin
        idle = 1'b1;
        if (start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        ch_start  = '1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (run_seen && cores_quiet) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Work blob latched on an accepted start; threshold retimed every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blob         <= '0;
      ch_threshold <= '0;
    end else begin
      ch_threshold <= threshold;
      if (accept) blob <= blobby;
    end
  end

  // Per-core blob: base nonce offset by the core's share of the range
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ch_blobby[c]              = blob;
      ch_blobby[c][NONCE_INDEX] = blob[NONCE_INDEX] + 32'(c) * ch_scan_count[0];
    end
  end

`ifdef SHA3_SCANNER_EARLY_ABORT_EN
  logic aborted;
  logic abort_pulse;

  // First push of a job raises a one-cycle abort and closes capture for the job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted     <= 1'b0;
      abort_pulse <= 1'b0;
    end else if (accept) begin
      aborted     <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= push & ~aborted;
      if (push) aborted <= 1'b1;
    end
  end

  assign ch_abort     = {CHANNELS{abort_pulse}};
  assign capture_gate = {CHANNELS{~aborted}};
`else
  assign capture_gate = '1;
`endif

  assign take = ch_found & ~hold_valid & capture_gate;
  assign drop = ch_found &  hold_valid & capture_gate;

  // Number of results captured this cycle, added to the saturating counter
  always_comb begin
    ncap = '0;
    for (int c = 0; c < CHANNELS; c++) ncap = ncap + 5'(take[c]);
    found_sum = {1'b0, found_count} + 17'(ncap);
  end

  // Holding register occupancy: set on capture, cleared on grant or new job
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         hold_valid <= '0;
    else if (accept) hold_valid <= '0;
    else             hold_valid <= (hold_valid & ~grant_vec) | take;
  end

  // Holding register payload, qualified by hold_valid
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (take[c]) begin
        hold_hash[c]  <= ch_hash[c];
        hold_nonce[c] <= ch_nonce[c];
      end
    end
  end

  // Per-job overflow flag and saturating result counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      found_count <= '0;
    end else if (accept) begin
      overflow    <= 1'b0;
      found_count <= '0;
    end else begin
      if (|drop) overflow <= 1'b1;
      found_count <= found_sum[16] ? 16'hFFFF : found_sum[15:0];
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant;
    arb_idx   = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      arb_idx = (int'(last_grant) + i) % CHANNELS;
      if (!grant_any && hold_valid[arb_idx] && can_push) begin
        grant_any = 1'b1;
        grant_idx = CW'(arb_idx);
      end
    end
    grant_vec = grant_any ? (CHANNELS'(1) << grant_idx) : '0;
  end

  // Arbiter pointer; reset value makes channel 0 the first candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_grant <= CW'(CHANNELS - 1);
    else if (grant_any) last_grant <= grant_idx;
  end

  // A full FIFO still takes a push when its head is popped in the same cycle
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign res_valid = (wr_ptr != rd_ptr);
  assign pop       = res_valid & res_ready;
  assign can_push  = ~fifo_full | pop;
  assign push      = grant_any;

  // FIFO pointers, flushed on reset and on every accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
    end
  end

  // FIFO storage written from the granted holding register
  always_ff @(posedge clk) begin
    if (push) begin
      mem_hash[wr_ptr[AW-1:0]]  <= hold_hash[grant_idx];
      mem_nonce[wr_ptr[AW-1:0]] <= hold_nonce[grant_idx];
      mem_chan[wr_ptr[AW-1:0]]  <= grant_idx;
    end
  end

  assign res_hash    = mem_hash[rd_ptr[AW-1:0]];
  assign res_nonce   = mem_nonce[rd_ptr[AW-1:0]];
  assign res_channel = mem_chan[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_sha3_scanner_array.sv
//==============================================================================
// Module      : tb_sha3_scanner_array
// Description : Directed self-checking bench for sha3_scanner_array
//               (CHANNELS=2, RESULT_DEPTH=4). Honours
//               SHA3_SCANNER_EARLY_ABORT_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sha3_scanner_array;

  localparam int CHANNELS = 2;
  localparam int IE       = 20;
  localparam int NI       = 19;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               start;
  logic [IE-1:0][31:0]                blobby;
  logic [63:0]                        threshold;
  logic                               idle;
  logic [31:0]                        scan_count;
  logic [CHANNELS-1:0]                ch_start;
  logic [CHANNELS-1:0][IE-1:0][31:0]  ch_blobby;
  logic [63:0]                        ch_threshold;
`ifdef SHA3_SCANNER_EARLY_ABORT_EN
  logic [CHANNELS-1:0]                ch_abort;
`endif
  logic [CHANNELS-1:0]                ch_dispatching;
  logic [CHANNELS-1:0]                ch_awaiting;
  logic [CHANNELS-1:0]                ch_found;
  logic [CHANNELS-1:0][24:0][63:0]    ch_hash;
  logic [CHANNELS-1:0][31:0]          ch_nonce;
  logic [CHANNELS-1:0][31:0]          ch_scan_count;
  logic                               res_valid;
  logic                               res_ready;
  logic [24:0][63:0]                  res_hash;
  logic [31:0]                        res_nonce;
  logic [0:0]                         res_channel;
  logic                               overflow;
  logic [15:0]                        found_count;

  int total = 0;
  int bad   = 0;

  sha3_scanner_array #(
    .CHANNELS(CHANNELS), .INPUT_ELEMENTS(IE), .NONCE_INDEX(NI), .RESULT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .blobby(blobby), .threshold(threshold),
    .idle(idle), .scan_count(scan_count), .ch_start(ch_start), .ch_blobby(ch_blobby),
    .ch_threshold(ch_threshold),
`ifdef SHA3_SCANNER_EARLY_ABORT_EN
    .ch_abort(ch_abort),
`endif
    .ch_dispatching(ch_dispatching), .ch_awaiting(ch_awaiting), .ch_found(ch_found),
    .ch_hash(ch_hash), .ch_nonce(ch_nonce), .ch_scan_count(ch_scan_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash),
    .res_nonce(res_nonce), .res_channel(res_channel), .overflow(overflow),
    .found_count(found_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; blobby = '0; threshold = 64'h1234;
    ch_dispatching = '0; ch_awaiting = '0; ch_found = '0; ch_hash = '0;
    ch_nonce = '0; ch_scan_count = '0; res_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ch_start", 64'(ch_start), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_found_count", 64'(found_count), 64'd0);
    chk("rst_threshold", ch_threshold, 64'd0);
    rst = 1'b0;
    tick();

    // T1: base 0x100, stride 0x1000
    ch_scan_count[0] = 32'h1000; ch_scan_count[1] = 32'h1000;
    blobby[NI] = 32'h100; blobby[0] = 32'hDEADBEEF;
    ch_awaiting = 2'b11;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_idle_low", 64'(idle), 64'd0);
    chk("t1_ch_start", 64'(ch_start), 64'h3);
    chk("t1_nonce0", 64'(ch_blobby[0][NI]), 64'h100);
    chk("t1_nonce1", 64'(ch_blobby[1][NI]), 64'h1100);
    chk("t1_word0_c1", 64'(ch_blobby[1][0]), 64'hDEADBEEF);
    chk("t1_scan_count", 64'(scan_count), 64'h2000);
    chk("t1_threshold", ch_threshold, 64'h1234);
    tick();
    chk("t1_start_one_cycle", 64'(ch_start), 64'd0);

    // T5a: start during RUN ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_ignored_idle", 64'(idle), 64'd0);
    chk("t5_start_ignored_chstart", 64'(ch_start), 64'd0);
    chk("t5_blob_kept", 64'(ch_blobby[0][NI]), 64'h100);
    ch_awaiting = 2'b00;
    tick();
    chk("t1_back_idle", 64'(idle), 64'd1);

    // T2: nonce wrap, and minimum two RUN cycles with quiet cores
    blobby[NI] = 32'hFFFFF800;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_nonce0", 64'(ch_blobby[0][NI]), 64'hFFFFF800);
    chk("t2_nonce1_wrap", 64'(ch_blobby[1][NI]), 64'h00000800);
    tick(); tick();
    chk("t2_run_min2", 64'(idle), 64'd0);
    tick();
    chk("t2_idle_after_run", 64'(idle), 64'd1);

    // T3: simultaneous finds on both cores
    ch_awaiting = 2'b11; res_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ch_found = 2'b11;
    ch_hash[0][0] = 64'hA0; ch_hash[1][0] = 64'hB1;
    ch_nonce[0] = 32'h10; ch_nonce[1] = 32'h11;
    tick(); ch_found = 2'b00;
    chk("t3_found_count", 64'(found_count), 64'd2);
    chk("t3_fifo_empty_yet", 64'(res_valid), 64'd0);
    tick();
    chk("t3_head0_valid", 64'(res_valid), 64'd1);
    chk("t3_head0_chan", 64'(res_channel), 64'd0);
    chk("t3_head0_nonce", 64'(res_nonce), 64'h10);
    chk("t3_head0_hash", res_hash[0], 64'hA0);
    tick();
    chk("t3_head1_chan", 64'(res_channel), 64'd1);
    chk("t3_head1_nonce", 64'(res_nonce), 64'h11);
    chk("t3_head1_hash", res_hash[0], 64'hB1);
    tick();
    chk("t3_drained", 64'(res_valid), 64'd0);
    chk("t3_no_overflow", 64'(overflow), 64'd0);
    ch_awaiting = 2'b00;
    tick(); tick(); tick();
    chk("t3_idle", 64'(idle), 64'd1);

    // T4: six finds on core 0 into a stalled depth-4 FIFO
    res_ready = 1'b0; ch_awaiting = 2'b11;
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_count_cleared", 64'(found_count), 64'd0);
    for (int k = 0; k < 6; k++) begin
      ch_found = 2'b01; ch_nonce[0] = 32'h200 + 32'(k);
      tick(); ch_found = 2'b00;
      tick();
    end
    chk("t4_found_count", 64'(found_count), 64'd5);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_head", 64'(res_nonce), 64'h200);
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t4_drain_nonce", 64'(res_nonce), 64'h200 + 64'(k));
    end
    tick();
    chk("t4_sixth_dropped", 64'(res_valid), 64'd0);

    // T5b: async reset mid-RUN with a result pending
    res_ready = 1'b0;
    ch_found = 2'b10; ch_nonce[1] = 32'h300;
    tick(); ch_found = 2'b00;
    tick();
    chk("t5_pending", 64'(res_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_idle", 64'(idle), 64'd1);
    chk("t5_async_res_valid", 64'(res_valid), 64'd0);
    chk("t5_async_found_count", 64'(found_count), 64'd0);
    chk("t5_async_overflow", 64'(overflow), 64'd0);
    ch_awaiting = 2'b00;
    tick();
    rst = 1'b0;
    tick();

`ifdef SHA3_SCANNER_EARLY_ABORT_EN
    // T6: first result aborts all cores; later finds ignored
    ch_awaiting = 2'b11; res_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ch_found = 2'b10; ch_nonce[1] = 32'h400;
    tick(); ch_found = 2'b00;
    chk("t6_no_abort_yet", 64'(ch_abort), 64'd0);
    tick();
    chk("t6_abort_pulse", 64'(ch_abort), 64'h3);
    tick();
    chk("t6_abort_one_cycle", 64'(ch_abort), 64'd0);
    ch_found = 2'b01; ch_nonce[0] = 32'h401;
    tick(); ch_found = 2'b00;
    tick();
    chk("t6_found_count", 64'(found_count), 64'd1);
    chk("t6_no_overflow", 64'(overflow), 64'd0);
    chk("t6_head_chan", 64'(res_channel), 64'd1);
    res_ready = 1'b1;
    tick();
    chk("t6_single_entry", 64'(res_valid), 64'd0);
    ch_awaiting = 2'b00;
    tick(); tick(); tick();
    chk("t6_idle", 64'(idle), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
